// File: rtl/data_sram_bridge_if.sv
// rtl/data_sram_bridge_if.sv - split-transaction data SRAM bus (req / addr_ok / data_ok)
//
// Purpose: bundles the request/address-ok/data-ok bus between the bridge and
// the data RAM or cache.
// Modports:
//   master - bridge side: drives request, direction, size, address, strobes,
//            write data; receives addr_ok, data_ok and read data.
//   slave  - memory side: the mirror image of master.
interface data_sram_bridge_if;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/data_sram_bridge.sv
// rtl/data_sram_bridge.sv - CPU data-port to split-transaction SRAM bus bridge
//
// Purpose: converts the MEM stage's single-cycle data access into a
// request/addr_ok/data_ok transaction, stalling the pipeline until the
// response arrives and holding load data until the pipeline advances.
// Ports:
//   clka, rst       - clock, synchronous active-high reset
//   cpu_en/wen/size/addr/wdata/hold - access from the MEM stage
//   cpu_rdata       - load data, valid while in DONE
//   cpu_stall       - combinational pipeline freeze
//   cpu_addr_err    - one-cycle pulse for a misaligned access (in DONE)
//   bus             - data_sram_bridge_if.master
//   bus_timeout     - sticky flag: data_ok not seen within TIMEOUT_CYCLES
// Parameter TIMEOUT_CYCLES: WAIT cycles before bus_timeout sets; 0 disables.
// Optional macro ADDR_MAP_EN: map kseg0/kseg1 virtual addresses to physical
// on bus_addr; when undefined bus_addr is the latched address verbatim.
module data_sram_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clka,
  input  logic                rst,
  input  logic                cpu_en,
  input  logic [3:0]          cpu_wen,
  input  logic [1:0]          cpu_size,
  input  logic [31:0]         cpu_addr,
  input  logic [31:0]         cpu_wdata,
  input  logic                cpu_hold,
  output logic [31:0]         cpu_rdata,
  output logic                cpu_stall,
  output logic                cpu_addr_err,
  data_sram_bridge_if.master  bus,
  output logic                bus_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

  state_t        state_q, state_d;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [3:0]    wstrb_q;
  logic [1:0]    size_q;
  logic          wr_q;
  logic          addr_err_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic          misaligned;
  logic          capture;

  always_comb begin
    misaligned = 1'b0;
    case (cpu_size)
      2'd1:    misaligned = cpu_addr[0];
      2'd2:    misaligned = |cpu_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Read data is taken either on a same-cycle addr_ok+data_ok in REQ or on
  // data_ok in WAIT; data_ok anywhere else is a stale response and ignored.
  assign capture = ((state_q == REQ) && bus.bus_addr_ok && bus.bus_data_ok) ||
                   ((state_q == WAIT) && bus.bus_data_ok);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cpu_en) state_d = misaligned ? DONE : REQ;
      REQ:  if (bus.bus_addr_ok) state_d = bus.bus_data_ok ? DONE : WAIT;
      WAIT: if (bus.bus_data_ok) state_d = DONE;
      DONE: if (!cpu_hold) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter restarts on entry to WAIT and saturates at TIMEOUT_CYCLES.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if ((state_q == REQ) && bus.bus_addr_ok && !bus.bus_data_ok) begin
      cnt_d = '0;
    end else if ((state_q == WAIT) && (cnt_q != TO_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
    if ((TIMEOUT_CYCLES != 0) && (state_q == WAIT) && (cnt_d == TO_MAX)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      size_q     <= '0;
      wr_q       <= 1'b0;
      rdata_q    <= '0;
      addr_err_q <= 1'b0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      addr_err_q <= 1'b0;
      if ((state_q == IDLE) && cpu_en) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        wstrb_q <= cpu_wen;
        size_q  <= cpu_size;
        wr_q    <= |cpu_wen;
        if (misaligned) begin
          addr_err_q <= 1'b1;
          rdata_q    <= '0;
        end
      end
      if (capture) begin
        rdata_q <= bus.bus_rdata;
      end
    end
  end

  assign cpu_stall    = cpu_en & (state_q != DONE);
  assign cpu_rdata    = rdata_q;
  assign cpu_addr_err = addr_err_q;
  assign bus_timeout  = timeout_q;

  assign bus.bus_req   = (state_q == REQ);
  assign bus.bus_wr    = wr_q;
  assign bus.bus_size  = size_q;
  assign bus.bus_wstrb = wstrb_q;
  assign bus.bus_wdata = wdata_q;

`ifdef ADDR_MAP_EN
  // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) fold onto the low 512 MiB.
  assign bus.bus_addr = (addr_q[31:30] == 2'b10) ? {3'b000, addr_q[28:0]} : addr_q;
`else
  assign bus.bus_addr = addr_q;
`endif

endmodule

// File: tb/tb_data_sram_bridge.sv
// tb/tb_data_sram_bridge.sv - self-checking bench for data_sram_bridge
module tb_data_sram_bridge;
  localparam int TO = 4;

  logic        clka = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_en = 1'b0;
  logic [3:0]  cpu_wen = '0;
  logic [1:0]  cpu_size = '0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_hold = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_addr_err;
  logic        bus_timeout;

  int   errs = 0;
  int   checks = 0;
  logic exp_to = 1'b0;

  data_sram_bridge_if bus_if();

  data_sram_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clka(clka), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen),
    .cpu_size(cpu_size), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_hold(cpu_hold), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cpu_addr_err(cpu_addr_err), .bus(bus_if), .bus_timeout(bus_timeout)
  );

  always #5 clka = ~clka;

  function automatic logic [31:0] map_addr(input logic [31:0] a);
`ifdef ADDR_MAP_EN
    if (a[31:30] == 2'b10) return {3'b000, a[28:0]};
`endif
    return a;
  endfunction

  // One aligned access: addr_ok after a_wait extra REQ cycles, data_ok d_wait
  // cycles after addr_ok (0 = same cycle), then hold cycles in DONE.
  task automatic run_access(input logic [31:0] addr, input logic [3:0] wen,
                            input logic [1:0] size, input logic [31:0] wdata,
                            input int a_wait, input int d_wait,
                            input logic [31:0] rdata, input int hold, input string tag);
    int   ack_k  = 1 + a_wait + d_wait;
    int   done_k = 2 + a_wait + d_wait;
    int   waits;
    logic exp_req, exp_stall, exp_t;
    for (int k = 0; k <= done_k + hold; k++) begin
      @(negedge clka);
      cpu_en    = 1'b1;
      cpu_wen   = wen;
      cpu_size  = size;
      cpu_addr  = (k == 0) ? addr : $urandom;
      cpu_wdata = (k == 0) ? wdata : $urandom;
      cpu_hold  = (k >= done_k) && (k < done_k + hold);
      bus_if.bus_addr_ok = (k == 1 + a_wait) ||
                           (((k == 0) || (k > 1 + a_wait)) && 1'($urandom_range(0, 1)));
      bus_if.bus_data_ok = (k == ack_k) ||
                           (((k == 0) || (k < 1 + a_wait) || (k >= done_k)) && 1'($urandom_range(0, 1)));
      bus_if.bus_rdata   = (k == ack_k) ? rdata : $urandom;
      #1;
      exp_stall = (k < done_k);
      exp_req   = (k >= 1) && (k <= 1 + a_wait);
      waits     = k - (2 + a_wait);
      if (waits < 0) waits = 0;
      if (waits > d_wait) waits = d_wait;
      exp_t = exp_to | ((TO != 0) && (waits >= TO));
      checks++; if (cpu_stall !== exp_stall) begin errs++; $display("FAIL %s stall k=%0d got %b want %b", tag, k, cpu_stall, exp_stall); end
      checks++; if (bus_if.bus_req !== exp_req) begin errs++; $display("FAIL %s bus_req k=%0d got %b want %b", tag, k, bus_if.bus_req, exp_req); end
      checks++; if (bus_timeout !== exp_t) begin errs++; $display("FAIL %s timeout k=%0d got %b want %b", tag, k, bus_timeout, exp_t); end
      checks++; if (cpu_addr_err !== 1'b0) begin errs++; $display("FAIL %s addr_err k=%0d got %b want 0", tag, k, cpu_addr_err); end
      if (exp_req) begin
        checks++; if (bus_if.bus_addr !== map_addr(addr)) begin errs++; $display("FAIL %s bus_addr k=%0d got %h want %h", tag, k, bus_if.bus_addr, map_addr(addr)); end
        checks++; if (bus_if.bus_wr !== (|wen)) begin errs++; $display("FAIL %s bus_wr k=%0d got %b want %b", tag, k, bus_if.bus_wr, |wen); end
        checks++; if (bus_if.bus_wstrb !== wen) begin errs++; $display("FAIL %s wstrb k=%0d got %h want %h", tag, k, bus_if.bus_wstrb, wen); end
        checks++; if (bus_if.bus_wdata !== wdata) begin errs++; $display("FAIL %s wdata k=%0d got %h want %h", tag, k, bus_if.bus_wdata, wdata); end
        checks++; if (bus_if.bus_size !== size) begin errs++; $display("FAIL %s size k=%0d got %0d want %0d", tag, k, bus_if.bus_size, size); end
      end
      if ((k >= done_k) && (wen == 4'b0000)) begin
        checks++; if (cpu_rdata !== rdata) begin errs++; $display("FAIL %s rdata k=%0d got %h want %h", tag, k, cpu_rdata, rdata); end
      end
    end
    if ((TO != 0) && (d_wait >= TO)) exp_to = 1'b1;
    @(negedge clka);
    cpu_en = 1'b0; cpu_hold = 1'b0;
    bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b0;
    #1;
    checks++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL %s idle_stall got %b want 0", tag, cpu_stall); end
    checks++; if (bus_if.bus_req !== 1'b0) begin errs++; $display("FAIL %s idle_req got %b want 0", tag, bus_if.bus_req); end
    if (wen == 4'b0000) begin
      checks++; if (cpu_rdata !== rdata) begin errs++; $display("FAIL %s idle_rdata got %h want %h", tag, cpu_rdata, rdata); end
    end
  endtask

  task automatic test_reset;
    @(negedge clka);
    rst = 1'b1; cpu_en = 1'b0;
    bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b0; bus_if.bus_rdata = '0;
    @(negedge clka); #1;
    checks++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL reset stall got %b want 0", cpu_stall); end
    checks++; if (cpu_addr_err !== 1'b0) begin errs++; $display("FAIL reset addr_err got %b want 0", cpu_addr_err); end
    checks++; if (cpu_rdata !== 32'h0) begin errs++; $display("FAIL reset rdata got %h want 0", cpu_rdata); end
    checks++; if (bus_if.bus_req !== 1'b0) begin errs++; $display("FAIL reset req got %b want 0", bus_if.bus_req); end
    checks++; if ({bus_if.bus_wr, bus_if.bus_size, bus_if.bus_wstrb} !== 7'h0) begin errs++; $display("FAIL reset ctl got %h want 0", {bus_if.bus_wr, bus_if.bus_size, bus_if.bus_wstrb}); end
    checks++; if ({bus_if.bus_addr, bus_if.bus_wdata} !== 64'h0) begin errs++; $display("FAIL reset addr_wdata got %h want 0", {bus_if.bus_addr, bus_if.bus_wdata}); end
    checks++; if (bus_timeout !== 1'b0) begin errs++; $display("FAIL reset timeout got %b want 0", bus_timeout); end
    rst = 1'b0;
  endtask

  task automatic test_word_load;
    run_access(32'h0000_1004, 4'b0000, 2'd2, 32'h0, 0, 2, 32'hDEAD_BEEF, 0, "word_load");
  endtask

  task automatic test_byte_store;
    run_access(32'h0000_2002, 4'b0100, 2'd0, 32'h00AB_0000, 0, 0, $urandom, 0, "byte_store");
  endtask

  task automatic test_misaligned(input logic [31:0] addr, input logic [1:0] size, input string tag);
    @(negedge clka);
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_size = size; cpu_addr = addr; cpu_hold = 1'b0;
    bus_if.bus_addr_ok = 1'b1; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errs++; $display("FAIL %s stall0 got %b want 1", tag, cpu_stall); end
    checks++; if (bus_if.bus_req !== 1'b0) begin errs++; $display("FAIL %s req0 got %b want 0", tag, bus_if.bus_req); end
    @(negedge clka);
    cpu_addr = $urandom;
    #1;
    checks++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL %s stall1 got %b want 0", tag, cpu_stall); end
    checks++; if (cpu_addr_err !== 1'b1) begin errs++; $display("FAIL %s err1 got %b want 1", tag, cpu_addr_err); end
    checks++; if (cpu_rdata !== 32'h0) begin errs++; $display("FAIL %s rdata got %h want 0", tag, cpu_rdata); end
    checks++; if (bus_if.bus_req !== 1'b0) begin errs++; $display("FAIL %s req1 got %b want 0", tag, bus_if.bus_req); end
    @(negedge clka);
    cpu_en = 1'b0; bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b0;
    #1;
    checks++; if (cpu_addr_err !== 1'b0) begin errs++; $display("FAIL %s err2 got %b want 0", tag, cpu_addr_err); end
    checks++; if (bus_if.bus_req !== 1'b0) begin errs++; $display("FAIL %s req2 got %b want 0", tag, bus_if.bus_req); end
  endtask

  task automatic test_hold;
    run_access(32'h0000_0040, 4'b0000, 2'd2, 32'h0, 1, 1, 32'h1234_5678, 3, "hold");
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [1:0]  sz;
    logic [3:0]  w;
    for (int i = 0; i < 24; i++) begin
      sz = 2'($urandom_range(0, 2));
      a  = $urandom;
      if (sz == 2'd1) a[0] = 1'b0;
      if (sz == 2'd2) a[1:0] = 2'b00;
      w  = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      run_access(a, w, sz, $urandom, $urandom_range(0, 2), $urandom_range(0, 3),
                 $urandom, $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_timeout;
    run_access(32'h0000_5000, 4'b0000, 2'd2, 32'h0, 0, 7, 32'hCAFE_F00D, 0, "timeout");
    run_access(32'h0000_5004, 4'b0000, 2'd2, 32'h0, 0, 1, 32'h0BAD_F00D, 0, "timeout_sticky");
  endtask

  task automatic test_reset_mid;
    @(negedge clka);
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_size = 2'd2; cpu_addr = 32'h0000_6000;
    bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b0;
    @(negedge clka);
    bus_if.bus_addr_ok = 1'b1;
    @(negedge clka);
    bus_if.bus_addr_ok = 1'b0;
    #1;
    checks++; if ({cpu_stall, bus_if.bus_req} !== 2'b10) begin errs++; $display("FAIL rst_mid wait got %b want 10", {cpu_stall, bus_if.bus_req}); end
    rst = 1'b1; cpu_en = 1'b0;
    @(negedge clka);
    rst = 1'b0;
    exp_to = 1'b0;
    #1;
    checks++; if (cpu_rdata !== 32'h0) begin errs++; $display("FAIL rst_mid rdata got %h want 0", cpu_rdata); end
    checks++; if (bus_if.bus_addr !== 32'h0) begin errs++; $display("FAIL rst_mid addr got %h want 0", bus_if.bus_addr); end
    checks++; if (bus_timeout !== 1'b0) begin errs++; $display("FAIL rst_mid timeout got %b want 0", bus_timeout); end
    @(negedge clka);
    bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h5555_AAAA;
    @(negedge clka);
    bus_if.bus_data_ok = 1'b0;
    #1;
    checks++; if (cpu_rdata !== 32'h0) begin errs++; $display("FAIL rst_mid stale_rdata got %h want 0", cpu_rdata); end
    checks++; if ({cpu_stall, bus_if.bus_req} !== 2'b00) begin errs++; $display("FAIL rst_mid idle got %b want 00", {cpu_stall, bus_if.bus_req}); end
    run_access(32'h0000_6004, 4'b0000, 2'd2, 32'h0, 0, 1, 32'h7777_1111, 0, "after_reset");
  endtask

  task automatic test_addr_map;
    run_access(32'hBFC0_0010, 4'b0000, 2'd2, 32'h0, 0, 0, 32'h0102_0304, 0, "map_kseg1");
    run_access(32'h8000_0100, 4'b1111, 2'd2, 32'hA5A5_5A5A, 1, 0, 32'h0, 0, "map_kseg0");
    run_access(32'h4000_0200, 4'b0000, 2'd2, 32'h0, 0, 1, 32'h0F0F_0F0F, 0, "map_kuseg");
  endtask

  initial begin
    bus_if.bus_addr_ok = 1'b0;
    bus_if.bus_data_ok = 1'b0;
    bus_if.bus_rdata   = '0;
    test_reset;
    test_word_load;
    test_byte_store;
    test_misaligned(32'h0000_3001, 2'd1, "mis_half");
    run_access(32'h0000_3100, 4'b0000, 2'd2, 32'h0, 0, 0, 32'h9999_8888, 0, "preload");
    test_misaligned(32'h0000_3002, 2'd2, "mis_word2");
    test_misaligned(32'h0000_3003, 2'd2, "mis_word3");
    test_hold;
    test_random;
    test_timeout;
    test_reset_mid;
    test_addr_map;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
Downstream of the CPU core's data-memory port. It takes the core's single-cycle data access (enable, byte write mask, address, write data) and turns it into a split-transaction request/address-ok/data-ok bus for data RAM or cache. It stalls the pipeline until the transaction completes. Load data is held stable until the pipeline advances.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for data_ok after addr_ok before flagging bus_timeout; 0 disables the timeout.

Ports:
clka  input  1  system clock
rst  input  1  synchronous reset, active-high
cpu_en  input  1  data access request from the MEM stage
cpu_wen  input  4  byte write mask; 0000 = load
cpu_size  input  2  0=byte, 1=half, 2=word
cpu_addr  input  32  byte address (ALU result)
cpu_wdata  input  32  store data, already lane-shifted
cpu_hold  input  1  pipeline frozen by another stall source
cpu_rdata  output  32  load data, valid while state=DONE
cpu_stall  output  1  freeze pipeline
cpu_addr_err  output  1  one-cycle pulse: misaligned access
bus_req  output  1  request valid
bus_wr  output  1  1 = write
bus_size  output  2  copy of latched size
bus_addr  output  32  latched address
bus_wstrb  output  4  latched write mask
bus_wdata  output  32  latched write data
bus_addr_ok  input  1  request accepted
bus_data_ok  input  1  write done / read data valid
bus_rdata  input  32  read data
bus_timeout  output  1  sticky timeout flag

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset (any state, mid-transaction included): state=IDLE, all outputs 0, latches 0, timeout counter 0, bus_timeout cleared.
- cpu_stall = cpu_en & (state != DONE). This is combinational, so it is high in the same cycle cpu_en first rises.
- IDLE, cpu_en=1:
  - Latch addr/wdata/wstrb/size. bus_wr = |cpu_wen.
  - Misaligned means size=1 with addr[0]=1, or size=2 with addr[1:0]!=0. If misaligned: pulse cpu_addr_err, set cpu_rdata=0, go to DONE, no bus request.
  - Otherwise go to REQ.
- REQ: bus_req=1. bus_addr/size/wstrb/wdata/wr are stable from latches and never change while req=1.
  - addr_ok=1 and data_ok=0 -> WAIT.
  - addr_ok=1 and data_ok=1 in the same cycle -> capture rdata, go to DONE.
- WAIT: bus_req=0. data_ok=1 -> capture bus_rdata into cpu_rdata (writes capture too; the value is don't-care), go to DONE.
- DONE: stall released. cpu_hold=1 -> stay in DONE with cpu_rdata held. cpu_hold=0 -> IDLE; the pipeline advances this cycle. A new cpu_en in the next cycle starts a new access, giving a minimum of 3 cycles per access.
- data_ok outside WAIT (or REQ with same-cycle addr_ok) is ignored, e.g. a stale response after reset. addr_ok outside REQ is ignored.
- Timeout counter: cleared on entry to WAIT, increments each WAIT cycle. When it reaches TIMEOUT_CYCLES (nonzero), bus_timeout sets and stays set until reset. The FSM keeps waiting.
- The counter saturates and does not wrap.
- cpu_en dropping while in REQ/WAIT does not cancel the transaction. It completes and passes through DONE for one cycle.

Optional Feature:
ADDR_MAP_EN:
- Defined: bus_addr maps kseg0/kseg1 to physical. If cpu_addr[31:30]==2'b10, bus_addr = {3'b000, addr[28:0]}; other addresses pass unchanged.
- Undefined: bus_addr = latched cpu_addr verbatim.

Test Plan:
- Word load 0x0000_1004, addr_ok on cycle 1 of REQ, data_ok 2 cycles later with 0xDEADBEEF -> stall high exactly while cpu_en and not DONE; cpu_rdata=0xDEADBEEF in DONE; bus_req high 1 cycle.
- Byte store wen=0100, wdata=0x00AB0000, addr 0x2002, addr_ok and data_ok in the same cycle -> bus_wr=1, wstrb=0100, straight to DONE, no WAIT cycle.
- Half load at 0x3001 -> cpu_addr_err pulse 1 cycle, bus_req never asserted, cpu_rdata=0, one stall cycle.
- Load completes while cpu_hold=1 for 3 cycles -> FSM stays in DONE; cpu_rdata stable 3 cycles; IDLE after hold drops.
- rst asserted in WAIT, data_ok arrives 2 cycles later -> state IDLE, data_ok ignored, cpu_rdata=0. Separately, TIMEOUT_CYCLES=4 with no data_ok -> bus_timeout=1 after 4 WAIT cycles, stays set.
- With ADDR_MAP_EN: access 0xBFC0_0010 -> bus_addr=0x1FC0_0010; access 0x8000_0100 -> 0x0000_0100.
